// File: rtl/rate_sample_player.sv
// Rate-strobed PCM sample player: small FIFO, one pop per rate pulse, first-order delta-sigma output.
// Optional macro RATE_SAMPLE_HOLD_LAST_EN: on underflow keep the last sample instead of forcing midscale.
module rate_sample_player #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rate,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    output logic          underflow,
    input  logic          underflow_clr,
    output logic [AW:0]   level,
    output logic          pdm_out
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] LEVEL_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEVEL_EMPTY = {(AW+1){1'b0}};

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [DW:0]   acc_r;

    logic          push_s;
    logic          pop_s;
    logic          under_s;
    logic [DW-1:0] u_s;
    logic [DW:0]   sum_s;

    assign wr_ready = (level != LEVEL_FULL);

    // Handshake decode; a push into an empty FIFO is never popped on the same edge.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        under_s = 1'b0;
        if (wr_valid && (level != LEVEL_FULL)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (rate) begin
            pop_s   = (level != LEVEL_EMPTY);
            under_s = (level == LEVEL_EMPTY);
        end else begin
            pop_s   = 1'b0;
            under_s = 1'b0;
        end
    end

    // Sample storage; contents are don't-care after reset since level gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level    <= LEVEL_EMPTY;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Playing sample, valid pulse and sticky underflow (a new event beats the clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample       <= {DW{1'b0}};
            sample_valid <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            sample_valid <= pop_s;
            if (pop_s) begin
                sample <= mem_r[rd_ptr_r];
            end else if (under_s) begin
`ifdef RATE_SAMPLE_HOLD_LAST_EN
                sample <= sample;
`else
                sample <= {DW{1'b0}};
`endif
            end else begin
                sample <= sample;
            end
            if (under_s) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end else begin
                underflow <= underflow;
            end
        end
    end

    // Offset-binary input: the carry of the running sum has ones density u / 2^DW.
    always_comb begin
        u_s   = {~sample[DW-1], sample[DW-2:0]};
        sum_s = {1'b0, acc_r[DW-1:0]} + {1'b0, u_s};
    end

    // Delta-sigma accumulator and registered carry output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= {(DW+1){1'b0}};
            pdm_out <= 1'b0;
        end else begin
            acc_r   <= sum_s;
            pdm_out <= sum_s[DW];
        end
    end

endmodule

// File: tb/tb_rate_sample_player.sv
// Self-checking bench for rate_sample_player against a queue-based behavioural model.
module tb_rate_sample_player;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rate = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] sample;
    logic        sample_valid;
    logic        underflow;
    logic        underflow_clr = 1'b0;
    logic [4:0]  level;
    logic        pdm_out;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [15:0] q[$];
    logic [15:0] m_sample = 16'h0000;
    logic        m_sv = 1'b0;
    logic        m_uf = 1'b0;
    int          m_acc = 0;
    logic        m_pdm = 1'b0;

    rate_sample_player #(.DW(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .rate(rate), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .sample(sample),
        .sample_valid(sample_valid), .underflow(underflow),
        .underflow_clr(underflow_clr), .level(level), .pdm_out(pdm_out)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit push, pop;
        int u;
        @(posedge clk);
        push = wr_valid && (q.size() != 16);
        pop  = rate && (q.size() != 0);
        u = int'(m_sample) ^ 32'h8000;
        m_acc = (m_acc % 65536) + u;
        m_pdm = (m_acc >= 65536);
        m_sv = pop;
        if (pop) m_sample = q.pop_front();
        else if (rate) begin
`ifndef RATE_SAMPLE_HOLD_LAST_EN
            m_sample = 16'h0000;
`endif
        end
        if (rate && !pop) m_uf = 1'b1;
        else if (underflow_clr) m_uf = 1'b0;
        if (push) q.push_back(wr_data);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_sample = 16'h0000; m_sv = 1'b0; m_uf = 1'b0; m_acc = 0; m_pdm = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_vec++; if (sample !== 16'h0000) begin n_err++; $display("FAIL reset_sample got %h want 0000", sample); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %b want 0", underflow); end
        n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_sample_valid got %b want 0", sample_valid); end
        n_vec++; if (pdm_out !== 1'b0) begin n_err++; $display("FAIL reset_pdm got %b want 0", pdm_out); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (pdm_out !== 1'(i % 2) || pdm_out !== m_pdm) begin
                n_err++; $display("FAIL idle_pdm cycle %0d got %b want %b", i, pdm_out, 1'(i % 2));
            end
        end
    endtask

    task automatic test_play();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h8000; words[2] = 16'h7FFF;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = words[i]; tick();
        end
        wr_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            rate = 1'b1; tick(); rate = 1'b0;
            n_vec++; if (sample !== words[p]) begin n_err++; $display("FAIL play_sample %0d got %h want %h", p, sample, words[p]); end
            n_vec++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL play_valid %0d got %b want 1", p, sample_valid); end
            n_vec++; if (level !== 5'(2 - p)) begin n_err++; $display("FAIL play_level %0d got %0d want %0d", p, level, 2 - p); end
            for (int c = 0; c < 383; c++) begin
                tick();
                if (c == 0) begin
                    n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL play_valid_width %0d got %b want 0", p, sample_valid); end
                end
                if (pdm_out !== m_pdm) begin
                    n_vec++; n_err++; $display("FAIL play_pdm %0d cycle %0d got %b want %b", p, c, pdm_out, m_pdm);
                end
            end
            n_vec++;
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 16'($urandom); tick();
        end
        wr_data = 16'hABCD; tick();
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready got %b want 0", wr_ready); end
        n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL full_level got %0d want 16", level); end
        rate = 1'b1; tick(); rate = 1'b0;
        n_vec++; if (level !== 5'd15 || sample !== m_sample) begin n_err++; $display("FAIL full_pop level %0d sample %h want 15 %h", level, sample, m_sample); end
        tick(); wr_valid = 1'b0;
        n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL full_refill got %0d want 16", level); end
        while (q.size() != 0) begin
            rate = 1'b1; tick(); rate = 1'b0;
            n_vec++; if (sample !== m_sample || sample_valid !== 1'b1) begin n_err++; $display("FAIL drain_sample got %h/%b want %h/1", sample, sample_valid, m_sample); end
            repeat ($urandom_range(1, 4)) tick();
        end
        n_vec++; if (sample !== 16'hABCD) begin n_err++; $display("FAIL drain_last got %h want abcd", sample); end
    endtask

    task automatic test_underflow();
        logic [15:0] exp;
        wr_valid = 1'b1; wr_data = 16'h4000; tick(); wr_valid = 1'b0;
        rate = 1'b1; tick(); rate = 1'b0;
        n_vec++; if (sample !== 16'h4000) begin n_err++; $display("FAIL uf_play got %h want 4000", sample); end
        tick();
        rate = 1'b1; tick(); rate = 1'b0;
`ifdef RATE_SAMPLE_HOLD_LAST_EN
        exp = 16'h4000;
`else
        exp = 16'h0000;
`endif
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag got %b want 1", underflow); end
        n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL uf_valid got %b want 0", sample_valid); end
        n_vec++; if (sample !== exp) begin n_err++; $display("FAIL uf_sample got %h want %h", sample, exp); end
        tick();
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got %b want 1", underflow); end
        underflow_clr = 1'b1; rate = 1'b1; tick(); rate = 1'b0;
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set_wins got %b want 1", underflow); end
        tick(); underflow_clr = 1'b0;
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear got %b want 0", underflow); end
    endtask

    task automatic test_push_rate_empty();
        wr_valid = 1'b1; wr_data = 16'h5A5A; rate = 1'b1; tick();
        wr_valid = 1'b0; rate = 1'b0;
        n_vec++; if (underflow !== 1'b1 || level !== 5'd1 || sample_valid !== 1'b0) begin
            n_err++; $display("FAIL push_rate_empty uf %b level %0d valid %b want 1 1 0", underflow, level, sample_valid);
        end
        tick();
        rate = 1'b1; tick(); rate = 1'b0;
        n_vec++; if (sample !== 16'h5A5A || level !== 5'd0 || sample_valid !== 1'b1) begin
            n_err++; $display("FAIL push_rate_next sample %h level %0d valid %b want 5a5a 0 1", sample, level, sample_valid);
        end
        underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data = 16'($urandom);
            rate = ($urandom_range(0, 5) == 0);
            underflow_clr = ($urandom_range(0, 19) == 0);
            tick();
            n_vec++;
            if (sample !== m_sample || sample_valid !== m_sv || underflow !== m_uf ||
                level !== 5'(q.size()) || wr_ready !== (q.size() != 16) || pdm_out !== m_pdm) begin
                n_err++;
                $display("FAIL random cycle %0d got s=%h v=%b u=%b l=%0d r=%b p=%b want s=%h v=%b u=%b l=%0d r=%b p=%b",
                         i, sample, sample_valid, underflow, level, wr_ready, pdm_out,
                         m_sample, m_sv, m_uf, q.size(), q.size() != 16, m_pdm);
            end
        end
        wr_valid = 1'b0; rate = 1'b0; underflow_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        model_reset();
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
        wr_valid = 1'b1; wr_data = 16'h7FFF; tick();
        wr_valid = 1'b0; rate = 1'b1; tick(); rate = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 16'($urandom); tick();
        end
        wr_valid = 1'b0;
        n_vec++; if (level !== 5'd5 || sample !== 16'h7FFF) begin n_err++; $display("FAIL arst_setup level %0d sample %h want 5 7fff", level, sample); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (level !== 5'd0 || sample !== 16'h0000 || sample_valid !== 1'b0 || underflow !== 1'b0 || pdm_out !== 1'b0) begin
            n_err++; $display("FAIL arst_outputs level %0d sample %h valid %b uf %b pdm %b want all zero", level, sample, sample_valid, underflow, pdm_out);
        end
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        rate = 1'b1; tick(); rate = 1'b0;
        n_vec++; if (underflow !== 1'b1 || sample_valid !== 1'b0 || level !== 5'd0) begin
            n_err++; $display("FAIL arst_underflow uf %b valid %b level %0d want 1 0 0", underflow, sample_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_full();
        test_underflow();
        test_push_rate_empty();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
